// File: rtl/counter_pkg.sv
// counter_pkg: direction and limit-mode constants shared by the counter family.
package counter_pkg;
  localparam logic MODE_DOWN = 1'b0;
  localparam logic MODE_UP = 1'b1;
  localparam int LIM_WRAP = 0;
  localparam int LIM_SAT = 1;
endpackage

// File: rtl/counter_next.sv
// counter_next: next count and limit-hit flag for one up/down step in 0..MAX_VAL.
module counter_next
  import counter_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int MAX_VAL = 2**WIDTH-1,
  parameter int SAT = LIM_WRAP
) (
  input  logic [WIDTH-1:0] cur,
  input  logic [WIDTH-1:0] s,
  input  logic             mode,
  output logic [WIDTH-1:0] nxt,
  output logic             hit
);
  localparam logic [WIDTH:0] MAXP = (WIDTH+1)'(MAX_VAL);
  localparam logic [WIDTH:0] MODP = MAXP + 1'b1;
  logic [WIDTH:0] cur_x, s_x, sum, wrap_dn, res;
  always_comb begin
    cur_x = {1'b0, cur};
    s_x = {1'b0, s};
    sum = cur_x + s_x;
    wrap_dn = cur_x + MODP - s_x;
    hit = (mode == MODE_UP) ? (sum > MAXP) : (s_x > cur_x);
    res = (mode == MODE_UP)
        ? (hit ? ((SAT == LIM_SAT) ? MAXP : sum - MODP) : sum)
        : (hit ? ((SAT == LIM_SAT) ? '0 : wrap_dn) : cur_x - s_x);
    nxt = res[WIDTH-1:0];
  end
endmodule

// File: rtl/updown_mod_counter.sv
// updown_mod_counter: loadable modulo up/down counter with step, wrap/saturate,
// one-cycle terminal count and sticky overflow.
module updown_mod_counter
  import counter_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int MAX_VAL = 2**WIDTH-1,
  parameter int SAT = LIM_WRAP
) (
  input  logic             clock,
  input  logic             rst,
  input  logic             load,
  input  logic             en,
  input  logic             mode,
  input  logic [WIDTH-1:0] din,
  input  logic [WIDTH-1:0] step,
  output logic [WIDTH-1:0] dout,
  output logic             tc,
  output logic             ovf,
  output logic             at_zero,
  output logic             at_max
);
  localparam logic [WIDTH:0] MAXP = (WIDTH+1)'(MAX_VAL);
  localparam logic [WIDTH-1:0] MAXW = WIDTH'(MAX_VAL);
  logic [WIDTH-1:0] dout_q, dout_d, s, din_c, nxt;
  logic tc_q, tc_d, ovf_q, ovf_d, hit;
  counter_next #(.WIDTH(WIDTH), .MAX_VAL(MAX_VAL), .SAT(SAT)) u_next (
    .cur(dout_q), .s(s), .mode(mode), .nxt(nxt), .hit(hit)
  );
  always_comb begin
    s = ({1'b0, step} > MAXP) ? MAXW : step;
    din_c = ({1'b0, din} > MAXP) ? MAXW : din;
    dout_d = load ? din_c : en ? nxt : dout_q;
    tc_d = !load && en && hit;
    ovf_d = !load && (ovf_q || tc_d);
  end
  always_ff @(posedge clock) begin
    if (rst) begin
      dout_q <= '0;
      tc_q <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      dout_q <= dout_d;
      tc_q <= tc_d;
      ovf_q <= ovf_d;
    end
  end
  assign dout = dout_q;
  assign tc = tc_q;
  assign ovf = ovf_q;
  assign at_zero = (dout_q == '0);
  assign at_max = (dout_q == MAXW);
endmodule

// File: tb/tb_updown_mod_counter.sv
// tb_updown_mod_counter: directed vectors pushed into a scoreboard, checked by a monitor.
module tb_updown_mod_counter;
  import counter_pkg::*;
  logic clock = 1'b0;
  logic rst = 1'b1, load = 1'b0, en = 1'b0, mode = MODE_UP;
  logic [7:0] din = '0, step = '0;
  logic [3:0] a_dout, b_dout;
  logic [7:0] c_dout;
  logic a_tc, a_ovf, a_az, a_am, b_tc, b_ovf, b_az, b_am, c_tc, c_ovf, c_az, c_am;
  always #5 clock = ~clock;
  updown_mod_counter #(.WIDTH(4), .MAX_VAL(9), .SAT(LIM_WRAP)) dut_a (
    .clock(clock), .rst(rst), .load(load), .en(en), .mode(mode), .din(din[3:0]),
    .step(step[3:0]), .dout(a_dout), .tc(a_tc), .ovf(a_ovf), .at_zero(a_az), .at_max(a_am));
  updown_mod_counter #(.WIDTH(4), .MAX_VAL(9), .SAT(LIM_SAT)) dut_b (
    .clock(clock), .rst(rst), .load(load), .en(en), .mode(mode), .din(din[3:0]),
    .step(step[3:0]), .dout(b_dout), .tc(b_tc), .ovf(b_ovf), .at_zero(b_az), .at_max(b_am));
  updown_mod_counter dut_c (
    .clock(clock), .rst(rst), .load(load), .en(en), .mode(mode), .din(din),
    .step(step), .dout(c_dout), .tc(c_tc), .ovf(c_ovf), .at_zero(c_az), .at_max(c_am));
  typedef struct {
    int dut;
    logic [7:0] dout;
    logic tc, ovf, az, am;
    string name;
  } exp_t;
  exp_t q[$];
  int n_vec = 0, n_err = 0, n_push = 0;
  task automatic apply(input int d, input logic r, l, e, m, input logic [7:0] di, st,
                       input logic [7:0] ed, input logic et, eo, input string nm);
    exp_t x;
    @(negedge clock);
    rst = r; load = l; en = e; mode = m; din = di; step = st;
    x.dut = d; x.dout = ed; x.tc = et; x.ovf = eo; x.name = nm;
    x.az = (ed == 8'd0);
    x.am = (ed == ((d == 2) ? 8'd255 : 8'd9));
    q.push_back(x);
    n_push++;
  endtask
  initial begin
    forever begin
      @(posedge clock);
      #1;
      if (q.size() > 0) begin
        exp_t x;
        logic [7:0] ad;
        logic at, ao, az, am;
        x = q.pop_front();
        if (x.dut == 0) begin ad = {4'd0, a_dout}; at = a_tc; ao = a_ovf; az = a_az; am = a_am; end
        else if (x.dut == 1) begin ad = {4'd0, b_dout}; at = b_tc; ao = b_ovf; az = b_az; am = b_am; end
        else begin ad = c_dout; at = c_tc; ao = c_ovf; az = c_az; am = c_am; end
        n_vec++;
        if ({ad, at, ao, az, am} !== {x.dout, x.tc, x.ovf, x.az, x.am}) begin
          n_err++;
          $display("FAIL %s: dut%0d got dout=%0d tc=%b ovf=%b az=%b am=%b, want dout=%0d tc=%b ovf=%b az=%b am=%b",
                   x.name, x.dut, ad, at, ao, az, am, x.dout, x.tc, x.ovf, x.az, x.am);
        end
      end
    end
  end
  initial begin
    int waited;
    apply(0, 1, 1, 0, MODE_UP,   5, 0, 0, 0, 0, "rst_over_load");
    apply(0, 0, 1, 0, MODE_UP,   6, 0, 6, 0, 0, "load6");
    apply(0, 0, 0, 1, MODE_UP,   0, 1, 7, 0, 0, "up7");
    apply(0, 0, 0, 1, MODE_UP,   0, 1, 8, 0, 0, "up8");
    apply(0, 0, 0, 1, MODE_UP,   0, 1, 9, 0, 0, "up9");
    apply(0, 0, 0, 1, MODE_UP,   0, 1, 0, 1, 1, "wrap0");
    apply(0, 0, 0, 1, MODE_UP,   0, 1, 1, 0, 1, "up1_ovf_sticky");
    apply(0, 0, 1, 0, MODE_DOWN, 1, 0, 1, 0, 0, "load1");
    apply(0, 0, 0, 1, MODE_DOWN, 0, 3, 8, 1, 1, "down_wrap8");
    apply(0, 0, 0, 1, MODE_DOWN, 0, 3, 5, 0, 1, "down5");
    apply(0, 0, 1, 0, MODE_DOWN, 4, 3, 4, 0, 0, "load4_clr_ovf");
    apply(0, 0, 0, 0, MODE_DOWN, 0, 3, 4, 0, 0, "hold");
    apply(0, 0, 1, 1, MODE_UP,  15, 1, 9, 0, 0, "load_clip_prio");
    apply(0, 0, 1, 0, MODE_UP,   3, 0, 3, 0, 0, "load3");
    apply(0, 0, 0, 1, MODE_UP,   0, 12, 2, 1, 1, "step_clip_wrap");
    apply(0, 1, 0, 1, MODE_UP,   0, 1, 0, 0, 0, "rst_over_en");
    apply(1, 0, 1, 0, MODE_UP,   8, 0, 8, 0, 0, "sat_load8");
    apply(1, 0, 0, 1, MODE_UP,   0, 3, 9, 1, 1, "sat_clamp_max");
    apply(1, 0, 0, 1, MODE_UP,   0, 3, 9, 1, 1, "sat_hold_max");
    apply(1, 0, 0, 0, MODE_UP,   0, 3, 9, 0, 1, "sat_idle");
    apply(1, 0, 0, 1, MODE_DOWN, 0, 12, 0, 0, 1, "sat_down_exact0");
    apply(1, 0, 0, 1, MODE_DOWN, 0, 1, 0, 1, 1, "sat_clamp_zero");
    apply(1, 0, 0, 1, MODE_DOWN, 0, 0, 0, 0, 1, "sat_step0");
    apply(2, 0, 1, 0, MODE_UP, 250, 0, 250, 0, 0, "full_load250");
    apply(2, 0, 0, 1, MODE_UP,   0, 10, 4, 1, 1, "full_wrap4");
    apply(2, 0, 0, 1, MODE_DOWN, 0, 0, 4, 0, 1, "full_step0");
    apply(2, 0, 0, 1, MODE_DOWN, 0, 5, 255, 1, 1, "full_down_wrap");
    apply(2, 0, 0, 1, MODE_UP,   0, 255, 254, 1, 1, "full_up255");
    apply(2, 1, 1, 1, MODE_UP,  77, 1, 0, 0, 0, "full_rst");
    @(negedge clock);
    rst = 1'b0; load = 1'b0; en = 1'b0;
    waited = 0;
    while (q.size() > 0 && waited < 20) begin
      @(posedge clock);
      waited++;
    end
    #2;
    if (q.size() > 0 || n_vec != n_push) begin
      n_err++;
      $display("FAIL drain: checked %0d of %0d vectors", n_vec, n_push);
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/updown_mod_counter.md
# updown_mod_counter

Parametrised synchronous up/down counter: the next generation of the 4-bit loadable up/down counter. It adds configurable width and modulus, a programmable step, count enable, and wrap-or-saturate limiting. Terminal-count and sticky-overflow flags are provided for downstream timers, dividers and event sequencers. Single clock domain.

## Interface
- `WIDTH`, default 8: counter, load and step width in bits (≥2).
- `MAX_VAL`, default 2**WIDTH-1: largest legal count. The count range is 0..MAX_VAL and the modulus is MAX_VAL+1. Requires 1 ≤ MAX_VAL ≤ 2**WIDTH-1.
- `SAT`, default 0: limit mode. 0 = wrap modulo MAX_VAL+1; 1 = saturate at 0 and MAX_VAL.
- `clock`, in, 1: rising-edge clock.
- `rst`, in, 1: synchronous, active-high reset.
- `load`, in, 1: parallel load of `din`.
- `en`, in, 1: count enable.
- `mode`, in, 1: direction. 1 = up, 0 = down.
- `din`, in, WIDTH: load value.
- `step`, in, WIDTH: increment or decrement magnitude per enabled cycle.
- `dout`, out, WIDTH: registered count.
- `tc`, out, 1: registered one-cycle flag; the last update crossed a limit.
- `ovf`, out, 1: sticky registered flag; a limit has been crossed since the last `rst` or `load`.
- `at_zero`, out, 1: combinational, `dout == 0`.
- `at_max`, out, 1: combinational, `dout == MAX_VAL`.

## Operation
- Update priority each rising edge: `rst` > `load` > `en` > hold.
- `rst`: `dout` = 0, `tc` = 0, `ovf` = 0.
- `load`: `dout` = min(`din`, MAX_VAL), `tc` = 0, `ovf` = 0. `mode` and `en` are ignored that cycle.
- Effective step is s = min(`step`, MAX_VAL). `step` = 0 with `en` holds `dout` and keeps `tc` = 0.
- Up count (`en`=1, `mode`=1):
  - Form the sum `dout`+s in WIDTH+1 bits.
  - If the sum ≤ MAX_VAL: `dout` = sum, `tc` = 0.
  - Otherwise, with SAT=0: `dout` = sum − (MAX_VAL+1). With SAT=1: `dout` = MAX_VAL.
  - In either limiting case: `tc` = 1 and `ovf` set.
- Down count (`en`=1, `mode`=0):
  - If s ≤ `dout`: `dout` = `dout` − s, `tc` = 0.
  - Otherwise, with SAT=0: `dout` = `dout` + (MAX_VAL+1) − s, computed in WIDTH+1 bits. With SAT=1: `dout` = 0.
  - In either limiting case: `tc` = 1 and `ovf` set.
- Saturate mode holding at a limit: each further enabled cycle in the same direction with s>0 asserts `tc` again (a clamp is a limit crossing).
- Hold (`en`=0, no `load`): `dout` and `ovf` keep their values; `tc` = 0.
- `ovf` is cleared only by `rst` or `load`.
- `dout` never leaves 0..MAX_VAL.
- No intermediate arithmetic result truncates silently. All comparisons use WIDTH+1 bits.

## Timing
- All state (`dout`, `tc`, `ovf`) updates on the rising edge of `clock`. There are no asynchronous paths.
- Latency from sampled inputs to `dout`/`tc`/`ovf` is 1 cycle.
- `at_zero` and `at_max` follow `dout` combinationally within the same cycle.
- Reset values: `dout` = 0, `tc` = 0, `ovf` = 0, `at_zero` = 1, `at_max` = 0 (MAX_VAL ≥ 1).
- `rst` asserted mid-count, together with `load` or `en`, wins. The next cycle shows reset values.
- `tc` is high for exactly the cycle following a limiting update. It is never high after `rst`, `load` or a hold cycle.
- Direction or step changes take effect on the next enabled edge. No pipeline flush is needed.

## Structure
- Shared package `counter_pkg`:
  - Constants `MODE_DOWN` = 1'b0, `MODE_UP` = 1'b1, `LIM_WRAP` = 0, `LIM_SAT` = 1.
  - The same package is used by the existing counter bench.
- One combinational sub-module, `counter_next`:
  - Inputs: current value, s, `mode`.
  - Outputs: next value and a limit-hit flag.
  - Parametrised by WIDTH, MAX_VAL, SAT.
- The top level holds the registers, the priority mux and the flag logic.

## Test plan
1. Reset with WIDTH=4, MAX_VAL=9, SAT=0: assert `rst` one cycle with `load`=1, `din`=5 → `dout`=0, `tc`=0, `ovf`=0, `at_zero`=1.
2. Decade wrap up: `load` `din`=6, then `en`=1, `mode`=1, `step`=1 for 5 cycles → `dout` 7, 8, 9, 0, 1. `tc`=1 only in the cycle `dout`=0. `ovf`=1 from then on.
3. Down wrap with step: `load` 1, then `en`=1, `mode`=0, `step`=3 → `dout`=8, `tc`=1. Next edge → 5, `tc`=0, `ovf` still 1. A subsequent `load` 4 → `ovf`=0.
4. Saturate with WIDTH=4, MAX_VAL=9, SAT=1: `load` 8, up, `step`=3 → `dout`=9, `tc`=1. Next enabled cycle → `dout`=9, `tc`=1, `at_max`=1. Then `en`=0 → `tc`=0, `ovf`=1.
5. Load clipping and priority: `load`=1, `en`=1, `din`=15 → `dout`=9, `tc`=0. `step`=12 is treated as 9: from `dout`=3 up with SAT=0 → `dout`=2, `tc`=1.
6. Full-range default (WIDTH=8, MAX_VAL=255): `load` 250, up, `step`=10 → `dout`=4, `tc`=1. Down, `step`=0 → `dout` holds at 4, `tc`=0.
